// File: rtl/mod_counter.sv
// Up/down modulo counter with enable prescaler, synchronous clear/load,
// registered terminal-count pulse, sticky wrap flag and selectable output encoding.
module mod_counter #(
    parameter int              WIDTH    = 32,
    parameter longint unsigned MODULO   = 64'd1 << WIDTH,
    parameter int              PRESCALE = 1,
    parameter int              OUT_MODE = 0
) (
    input  logic             clk,
    input  logic             neg_reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             wrap_ack,
    output logic [WIDTH-1:0] counter_out,
    output logic             tc,
    output logic             wrap_flag
);

    // MODULO may equal 2**WIDTH, so it is held in WIDTH+1 bits before deriving the top count.
    localparam logic [WIDTH:0]   MOD_W   = (WIDTH + 1)'(MODULO);
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MOD_W - (WIDTH + 1)'(1));
    localparam int               PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] r_cnt;
    logic [PW-1:0]    r_pre;
    logic             r_tc;
    logic             r_wrap_flag;

    logic             w_tick;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_wrap;
    logic [WIDTH-1:0] w_cnt_step;
    logic [WIDTH-1:0] w_load_sat;
    logic [WIDTH-1:0] w_out;

    assign w_tick    = en && (r_pre == PS_LAST);
    assign w_at_max  = (r_cnt == MAX_CNT);
    assign w_at_zero = (r_cnt == '0);
    // A wrap only counts when the step actually happens, i.e. clear and load are idle.
    assign w_wrap    = w_tick && !clear && !load && (up_dn ? w_at_max : w_at_zero);

    always_comb begin
        w_cnt_step = r_cnt;
        if (up_dn) begin
            w_cnt_step = w_at_max ? '0 : r_cnt + WIDTH'(1);
        end else begin
            w_cnt_step = w_at_zero ? MAX_CNT : r_cnt - WIDTH'(1);
        end
    end

    assign w_load_sat = (load_val > MAX_CNT) ? MAX_CNT : load_val;

    always_ff @(posedge clk or negedge neg_reset) begin
        if (!neg_reset) begin
            r_cnt       <= '0;
            r_pre       <= '0;
            r_tc        <= 1'b0;
            r_wrap_flag <= 1'b0;
        end else begin
            r_tc <= w_wrap;
            if (w_wrap) begin
                r_wrap_flag <= 1'b1;
            end else if (wrap_ack) begin
                r_wrap_flag <= 1'b0;
            end

            if (clear) begin
                r_cnt <= '0;
                r_pre <= '0;
            end else if (load) begin
                r_cnt <= w_load_sat;
                r_pre <= '0;
            end else if (en) begin
                r_pre <= w_tick ? '0 : r_pre + PW'(1);
                if (w_tick) begin
                    r_cnt <= w_cnt_step;
                end
            end
        end
    end

    always_comb begin
        w_out = r_cnt;
        if (OUT_MODE == 1) begin
            w_out = ~r_cnt;
        end else if (OUT_MODE == 2) begin
            w_out = ~r_cnt + WIDTH'(1);
        end
    end

    assign counter_out = w_out;
    assign tc          = r_tc;
    assign wrap_flag   = r_wrap_flag;

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: three configurations share one stimulus stream and are
// checked every cycle against an arithmetic model, plus directed literal sequences.
module tb_mod_counter;

    logic       clk;
    logic       neg_reset;
    logic       en;
    logic       up_dn;
    logic       clear;
    logic       load;
    logic [7:0] load_val;
    logic       wrap_ack;

    logic [7:0] out0;
    logic [3:0] out1;
    logic [7:0] out2;
    logic       tc0, tc1, tc2;
    logic       wf0, wf1, wf2;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    logic [7:0] exp_q[$];

    // ---------------- DUTs ----------------
    mod_counter #(.WIDTH(8), .MODULO(10), .PRESCALE(3), .OUT_MODE(2)) u0 (
        .clk(clk), .neg_reset(neg_reset), .en(en), .up_dn(up_dn), .clear(clear),
        .load(load), .load_val(load_val), .wrap_ack(wrap_ack),
        .counter_out(out0), .tc(tc0), .wrap_flag(wf0));

    mod_counter #(.WIDTH(4), .MODULO(10), .PRESCALE(1), .OUT_MODE(0)) u1 (
        .clk(clk), .neg_reset(neg_reset), .en(en), .up_dn(up_dn), .clear(clear),
        .load(load), .load_val(load_val[3:0]), .wrap_ack(wrap_ack),
        .counter_out(out1), .tc(tc1), .wrap_flag(wf1));

    mod_counter #(.WIDTH(8), .PRESCALE(1), .OUT_MODE(1)) u2 (
        .clk(clk), .neg_reset(neg_reset), .en(en), .up_dn(up_dn), .clear(clear),
        .load(load), .load_val(load_val), .wrap_ack(wrap_ack),
        .counter_out(out2), .tc(tc2), .wrap_flag(wf2));

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    longint c_mod[3] = '{10, 10, 256};
    int     c_ps[3]  = '{3, 1, 1};
    int     c_w[3]   = '{8, 4, 8};
    int     c_om[3]  = '{2, 0, 1};

    longint m_cnt[3] = '{0, 0, 0};
    int     m_pre[3] = '{0, 0, 0};
    bit     m_tc[3]  = '{0, 0, 0};
    bit     m_wf[3]  = '{0, 0, 0};

    always @(posedge clk or negedge neg_reset) begin
        if (!neg_reset) begin
            for (int k = 0; k < 3; k++) begin
                m_cnt[k] = 0;
                m_pre[k] = 0;
                m_tc[k]  = 0;
                m_wf[k]  = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                longint lv;
                bit     wrapped;
                lv      = longint'(load_val) % (64'd1 << c_w[k]);
                wrapped = 0;
                if (clear) begin
                    m_cnt[k] = 0;
                    m_pre[k] = 0;
                end else if (load) begin
                    m_cnt[k] = (lv < c_mod[k] - 1) ? lv : c_mod[k] - 1;
                    m_pre[k] = 0;
                end else if (en) begin
                    if (m_pre[k] + 1 == c_ps[k]) begin
                        m_pre[k] = 0;
                        if (up_dn) begin
                            wrapped  = (m_cnt[k] + 1 == c_mod[k]);
                            m_cnt[k] = (m_cnt[k] + 1) % c_mod[k];
                        end else begin
                            wrapped  = (m_cnt[k] == 0);
                            m_cnt[k] = (m_cnt[k] + c_mod[k] - 1) % c_mod[k];
                        end
                    end else begin
                        m_pre[k] = m_pre[k] + 1;
                    end
                end
                m_tc[k] = wrapped;
                if (wrapped)       m_wf[k] = 1;
                else if (wrap_ack) m_wf[k] = 0;
            end
        end
    end

    function automatic longint exp_out(int k);
        longint span;
        span = 64'd1 << c_w[k];
        case (c_om[k])
            1:       return span - 1 - m_cnt[k];
            2:       return (span - m_cnt[k]) % span;
            default: return m_cnt[k];
        endcase
    endfunction

    function automatic longint act_out(int k);
        case (k)
            0:       return longint'(out0);
            1:       return longint'(out1);
            default: return longint'(out2);
        endcase
    endfunction

    function automatic bit act_tc(int k);
        case (k)
            0:       return tc0;
            1:       return tc1;
            default: return tc2;
        endcase
    endfunction

    function automatic bit act_wf(int k);
        case (k)
            0:       return wf0;
            1:       return wf1;
            default: return wf2;
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("model_out_u%0d", k), act_out(k), exp_out(k));
                chk($sformatf("model_tc_u%0d", k), longint'(act_tc(k)), longint'(m_tc[k]));
                chk($sformatf("model_wf_u%0d", k), longint'(act_wf(k)), longint'(m_wf[k]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs change on the falling edge; the task returns at the next falling edge.
    task automatic drive(input bit c, input bit l, input logic [7:0] lv,
                         input bit e, input bit u, input bit a);
        clear    = c;
        load     = l;
        load_val = lv;
        en       = e;
        up_dn    = u;
        wrap_ack = a;
        @(negedge clk);
    endtask

    task automatic drive_rand(input int cycles, input bit allow_ack);
        for (int i = 0; i < cycles; i++) begin
            drive($urandom_range(0, 19) == 0,
                  $urandom_range(0, 14) == 0,
                  8'($urandom_range(0, 255)),
                  $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)),
                  allow_ack && ($urandom_range(0, 7) == 0));
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        neg_reset = 1'b0;
        clear = 0; load = 0; load_val = '0; en = 0; up_dn = 1; wrap_ack = 0;
        repeat (2) @(negedge clk);

        chk("reset_out_u0", longint'(out0), 64'h00);
        chk("reset_out_u2", longint'(out2), 64'hFF);
        chk("reset_tc_u1", longint'(tc1), 0);
        neg_reset = 1'b1;
        chk_en    = 1'b1;

        // up count with wrap on MODULO=10, WIDTH=4
        drive(1, 0, 8'd0, 0, 1, 0);
        exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd0, 8'd1};
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("upwrap_out_%0d", i), longint'(out1), longint'(exp_q.pop_front()));
            chk($sformatf("upwrap_tc_%0d", i), longint'(tc1), longint'(i == 10));
            drive(0, 0, 8'd0, 1, 1, 0);
        end
        chk("upwrap_flag", longint'(wf1), 1);

        // down count with prescale 3 from 1; out encoded as twos complement
        drive(0, 1, 8'd1, 0, 0, 0);
        exp_q = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hF7};
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("down_ps_out_%0d", i), longint'(out0), longint'(exp_q.pop_front()));
            chk($sformatf("down_ps_tc_%0d", i), longint'(tc0), longint'(i == 6));
            drive(0, 0, 8'd0, 1, 0, 0);
        end

        // clear beats load; load saturates; en=0 holds
        drive(1, 1, 8'd5, 1, 1, 0);
        chk("prio_clear_u0", longint'(out0), 64'h00);
        chk("prio_clear_u1", longint'(out1), 0);
        drive(0, 1, 8'd12, 0, 1, 0);
        chk("load_sat_u1", longint'(out1), 9);
        chk("load_sat_u0", longint'(out0), 64'hF7);
        chk("load_u2", longint'(out2), 64'hF3);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 8'd0, 0, 1, 0);
            chk($sformatf("hold_%0d", i), longint'(out1), 9);
        end

        // wrap_ack racing a wrap
        drive(0, 0, 8'd0, 0, 1, 1);
        chk("ack_clear", longint'(wf1), 0);
        drive(0, 0, 8'd0, 1, 1, 1);
        chk("race_out", longint'(out1), 0);
        chk("race_tc", longint'(tc1), 1);
        chk("race_flag", longint'(wf1), 1);
        drive(0, 0, 8'd0, 0, 1, 1);
        chk("ack_after_race", longint'(wf1), 0);

        // twos-complement encoding
        drive(0, 1, 8'd3, 0, 1, 0);
        chk("enc2_cnt3", longint'(out0), 64'hFD);
        drive(1, 0, 8'd0, 0, 1, 0);
        chk("enc2_cnt0", longint'(out0), 64'h00);

        drive_rand(400, 1);
        drive_rand(30, 0);

        // asynchronous reset between clock edges
        en = 1'b1;
        @(posedge clk);
        #2;
        neg_reset = 1'b0;
        #1;
        chk("async_out_u2", longint'(out2), 64'hFF);
        chk("async_out_u1", longint'(out1), 0);
        chk("async_tc_u0", longint'(tc0), 0);
        chk("async_wf_u1", longint'(wf1), 0);
        chk("async_wf_u2", longint'(wf2), 0);
        @(negedge clk);
        neg_reset = 1'b1;

        drive_rand(150, 1);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
